// File: rtl/ogpu_quad_store_arbiter.sv
`default_nettype none
// ogpu_quad_store_arbiter -- round-robin share of the HPS quad-store channel among
// NUM_REQ quad writers, four-phase handshake on the software ack PIO. Rev 1.0
module ogpu_quad_store_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        done,
   output logic                      quad_valid,
   output logic [ADDR_W-1:0]         quad_addr,
   output logic [DATA_W-1:0]         quad_data,
   output logic [2:0]                quad_owner,
   input  logic                      quad_store_ack,
   output logic                      timeout_err,
   input  logic                      err_clear
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                quad_valid_q, quad_valid_d;
   logic [ADDR_W-1:0]   quad_addr_q, quad_addr_d;
   logic [DATA_W-1:0]   quad_data_q, quad_data_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic                timeout_err_q, timeout_err_d;

   logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];
   logic                timeout_hit;
   logic                req_any;
   logic                hi_found;
   logic [IDX_W-1:0]    hi_idx;
   logic [IDX_W-1:0]    lo_idx;
   logic [IDX_W-1:0]    pick_idx;
   logic                retire;
   logic                err_set;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (wait_cnt_q == CNT_LAST);
   end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
   end

   // Two-pass priority search: lowest set bit at/after rr_ptr, else lowest set bit overall.
   always_comb begin
      req_any  = 1'b0;
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            req_any = 1'b1;
            lo_idx  = IDX_W'(i);
            if (IDX_W'(i) >= rr_ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = IDX_W'(i);
            end
         end
      end
      pick_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      state_d      = state_q;
      quad_valid_d = quad_valid_q;
      quad_addr_d  = quad_addr_q;
      quad_data_d  = quad_data_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      wait_cnt_d   = wait_cnt_q;
      done_d       = '0;
      retire       = 1'b0;
      err_set      = 1'b0;

      case (state_q)
         IDLE: begin
            // A stale ack left high by software blocks new grants.
            if (!quad_store_ack && req_any) begin
               state_d      = PRESENT;
               quad_valid_d = 1'b1;
               quad_addr_d  = addr_arr[pick_idx];
               quad_data_d  = data_arr[pick_idx];
               owner_d      = pick_idx;
               wait_cnt_d   = '0;
            end
         end
         PRESENT: begin
            if (quad_store_ack) begin
               retire = 1'b1;
            end else if (timeout_hit) begin
               retire  = 1'b1;
               err_set = 1'b1;
            end else if (wait_cnt_q != CNT_MAX) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!quad_store_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (retire) begin
         state_d          = RELEASE;
         quad_valid_d     = 1'b0;
         done_d[owner_q]  = 1'b1;
         rr_ptr_d         = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
      end

      // A new error outranks a simultaneous clear.
      timeout_err_d = err_set | (timeout_err_q & ~err_clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         quad_valid_q  <= 1'b0;
         quad_addr_q   <= '0;
         quad_data_q   <= '0;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         wait_cnt_q    <= '0;
         done_q        <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         quad_valid_q  <= quad_valid_d;
         quad_addr_q   <= quad_addr_d;
         quad_data_q   <= quad_data_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         wait_cnt_q    <= wait_cnt_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign done        = done_q;
   assign quad_valid  = quad_valid_q;
   assign quad_addr   = quad_addr_q;
   assign quad_data   = quad_data_q;
   assign quad_owner  = 3'(owner_q);
   assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ogpu_quad_store_arbiter.sv
`default_nettype none
// tb_ogpu_quad_store_arbiter -- directed scenarios plus randomized traffic checked
// against a transaction-level model of the quad-store arbiter. Rev 1.0
module tb_ogpu_quad_store_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 128;
   localparam int TIMEOUT = 16;

   logic                      clk = 1'b0;
   logic                      reset = 1'b1;
   logic [NUM_REQ-1:0]        req = '0;
   logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data = '0;
   logic [NUM_REQ-1:0]        done;
   logic                      quad_valid;
   logic [ADDR_W-1:0]         quad_addr;
   logic [DATA_W-1:0]         quad_data;
   logic [2:0]                quad_owner;
   logic                      quad_store_ack = 1'b0;
   logic                      timeout_err;
   logic                      err_clear = 1'b0;

   ogpu_quad_store_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
      .done(done), .quad_valid(quad_valid), .quad_addr(quad_addr), .quad_data(quad_data),
      .quad_owner(quad_owner), .quad_store_ack(quad_store_ack),
      .timeout_err(timeout_err), .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: the channel is either free, carrying one store awaiting ack, or
   // waiting for software to lower its ack after a store finished.
   logic               m_valid;
   logic [ADDR_W-1:0]  m_addr;
   logic [DATA_W-1:0]  m_data;
   logic [2:0]         m_owner;
   logic [NUM_REQ-1:0] m_done;
   logic               m_err;
   bit                 m_busy;
   bit                 m_draining;
   int                 m_ptr;
   int                 m_waited;

   bit watch3 = 0;
   bit saw3   = 0;
   int ack_hold = 0;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_addr = '0; m_data = '0; m_owner = '0; m_done = '0; m_err = 0;
      m_busy = 0; m_draining = 0; m_ptr = 0; m_waited = 0;
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
      for (int k = 0; k < NUM_REQ; k++)
         if (r[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic model_step();
      bit finish;
      bit expired;
      int w;
      finish  = 0;
      expired = 0;
      m_done  = '0;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_draining) begin
         if (!quad_store_ack) m_draining = 0;
      end else if (m_busy) begin
         if (quad_store_ack) finish = 1;
         else if (m_waited == TIMEOUT - 1) begin
            finish  = 1;
            expired = 1;
         end else m_waited++;
      end else if (!quad_store_ack && req != '0) begin
         w = rr_pick(req, m_ptr);
         m_busy   = 1;
         m_valid  = 1;
         m_owner  = 3'(w);
         m_addr   = req_addr[w*ADDR_W +: ADDR_W];
         m_data   = req_data[w*DATA_W +: DATA_W];
         m_waited = 0;
      end
      if (finish) begin
         m_done[m_owner] = 1'b1;
         m_valid    = 0;
         m_busy     = 0;
         m_draining = 1;
         m_ptr      = (int'(m_owner) + 1) % NUM_REQ;
      end
      if (expired) m_err = 1;
      else if (err_clear) m_err = 0;
   endtask

   task automatic compare_all();
      chk("valid", quad_valid, m_valid);
      chk("addr", quad_addr, m_addr);
      chk("data", quad_data, m_data);
      chk("owner", quad_owner, m_owner);
      chk("done", done, m_done);
      chk("timeout_err", timeout_err, m_err);
      if (watch3 && quad_valid && quad_owner == 3'd3) saw3 = 1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a);
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int fair_exp [5];
      fair_exp = '{0, 1, 2, 3, 0};
      model_reset();

      // Reset state
      do_reset();
      tick();
      chk("rst_valid", quad_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_owner", quad_owner, 0);

      // Single store with ack five cycles after quad_valid
      set_req(0, 32'h1000);
      req = 4'b0001;
      tick();
      chk("single_valid", quad_valid, 1);
      chk("single_addr", quad_addr, 32'h1000);
      chk("single_owner", quad_owner, 0);
      repeat (4) tick();
      quad_store_ack = 1'b1;
      tick();
      chk("single_done", done, 4'b0001);
      chk("single_valid_drop", quad_valid, 0);
      req = 4'b0000;
      tick();
      chk("single_done_once", done, 0);
      quad_store_ack = 1'b0;
      tick();

      // Round-robin fairness with all four requesting
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h2000 + 32'(i) * 32'h100);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_owner", quad_owner, fair_exp[k]);
         chk("rr_addr", quad_addr, 32'h2000 + 32'(fair_exp[k]) * 32'h100);
         quad_store_ack = 1'b1;
         tick();
         chk("rr_done", done, 4'b0001 << fair_exp[k]);
         quad_store_ack = 1'b0;
         tick();
      end
      req = 4'b0000;
      tick();

      // Stale ack held through reset blocks the grant
      quad_store_ack = 1'b1;
      do_reset();
      set_req(1, 32'h3300);
      req = 4'b0010;
      repeat (3) tick();
      chk("stale_no_grant", quad_valid, 0);
      quad_store_ack = 1'b0;
      tick();
      chk("stale_grant", quad_valid, 1);
      chk("stale_owner", quad_owner, 1);
      quad_store_ack = 1'b1;
      tick();
      req = 4'b0000;
      quad_store_ack = 1'b0;
      tick();

      // Timeout after exactly TIMEOUT cycles
      do_reset();
      set_req(2, 32'h4400);
      req = 4'b0100;
      tick();
      n = 0;
      for (int c = 1; c <= TIMEOUT + 4; c++) begin
         tick();
         if (done != '0) begin
            n = c;
            break;
         end
      end
      chk("timeout_cycles", n, TIMEOUT);
      chk("timeout_done", done, 4'b0100);
      chk("timeout_err_set", timeout_err, 1);
      req = 4'b0000;
      tick();
      chk("timeout_err_sticky", timeout_err, 1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("timeout_err_cleared", timeout_err, 0);

      // Ack on the expiry edge wins over the timeout
      set_req(0, 32'h5500);
      req = 4'b0001;
      tick();
      repeat (TIMEOUT - 1) tick();
      chk("collide_no_done_yet", done, 0);
      quad_store_ack = 1'b1;
      tick();
      chk("collide_done", done, 4'b0001);
      chk("collide_no_err", timeout_err, 0);
      req = 4'b0000;
      quad_store_ack = 1'b0;
      tick();

      // Requester 3 withdraws before it can be granted
      quad_store_ack = 1'b1;
      set_req(3, 32'h6600);
      req = 4'b1001;
      tick();
      watch3 = 1;
      saw3 = 0;
      req = 4'b0001;
      quad_store_ack = 1'b0;
      tick();
      chk("withdraw_owner", quad_owner, 0);
      quad_store_ack = 1'b1;
      tick();
      req = 4'b0000;
      quad_store_ack = 1'b0;
      repeat (5) tick();
      chk("withdraw_idle", quad_valid, 0);
      chk("withdraw_never3", saw3, 0);
      watch3 = 0;

      // Reset while a store is presented
      set_req(1, 32'h7700);
      req = 4'b0010;
      tick();
      tick();
      chk("midrst_pre_valid", quad_valid, 1);
      reset = 1'b1;
      #1;
      chk("midrst_valid", quad_valid, 0);
      chk("midrst_addr", quad_addr, 0);
      chk("midrst_data", quad_data, 0);
      chk("midrst_owner", quad_owner, 0);
      chk("midrst_done", done, 0);
      model_reset();
      req = 4'b0000;
      tick();
      reset = 1'b0;
      tick();
      chk("midrst_no_done", done, 0);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if (quad_store_ack) begin
            if (ack_hold == 0) quad_store_ack = 1'b0;
            else ack_hold--;
         end else if (m_valid ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 59) == 0)) begin
            quad_store_ack = 1'b1;
            ack_hold = $urandom_range(0, 3);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 7) == 0) begin
                  set_req(i, $urandom);
                  req[i] = 1'b1;
               end
            end else if (m_done[i]) begin
               if ($urandom_range(0, 3) == 0) set_req(i, $urandom);
               else req[i] = 1'b0;
            end else if (!(m_busy && int'(m_owner) == i)) begin
               if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
               req[i] = 1'b0;
            end
         end
         err_clear = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
